// File: rtl/tap_mult_seq.sv
// Sequential tap multiplier. Each accepted sample gives one accumulator-clear cycle and then NTAPS products.
// Define TAP_MULT_SEQ_DROP_CNT_EN to add drop_cnt_o, a saturating count of samples dropped while busy.
module tap_mult_seq #(
    parameter int NTAPS = 4,
    parameter int XW    = 16,
    parameter int CW    = 16,
    localparam int AW   = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic          clk,
    input  logic          GlobalReset,
    input  logic [XW-1:0] x_i,
    input  logic          srdyi_i,
    input  logic          coef_we_i,
    input  logic [AW-1:0] coef_addr_i,
    input  logic [CW-1:0] coef_data_i,
    output logic [31:0]   z_o,
    output logic          srdyo_o,
    output logic          sum_en_o,
    output logic          sum_rst_o,
`ifdef TAP_MULT_SEQ_DROP_CNT_EN
    output logic [7:0]    drop_cnt_o,
`endif
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, CLR, MUL} state_t;

    // k needs one extra bit so that it can hold NTAPS. That value marks the
    // extra cycle after the last product, when the strobes are dropped.
    localparam logic [AW:0] K_DONE = (AW+1)'(NTAPS);

    state_t               state_reg, state_next;
    logic [AW:0]          k_reg, k_next;
    logic signed [XW-1:0] sample_reg, sample_next;
    logic [31:0]          z_reg, z_next;
    logic                 srdyo_reg, srdyo_next;
    logic                 sum_en_reg, sum_en_next;
    logic                 sum_rst_reg, sum_rst_next;
    logic                 busy_reg, busy_next;

    logic signed [CW-1:0] coef_reg [NTAPS];
    logic                 coef_wr;
    logic signed [CW-1:0] coef_rd;
    logic signed [31:0]   prod;

    assign coef_wr = coef_we_i && (state_reg == IDLE) && ({1'b0, coef_addr_i} < K_DONE);

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef
            always_ff @(posedge clk) begin
                if (GlobalReset) begin
                    coef_reg[gi] <= '0;
                end else if (coef_wr && (coef_addr_i == AW'(gi))) begin
                    coef_reg[gi] <= coef_data_i;
                end
            end
        end
    endgenerate

    assign coef_rd = coef_reg[k_reg[AW-1:0]];
    // Both operands are sign-extended to 32 bits first. XW+CW <= 32, so the product is exact.
    assign prod    = 32'(sample_reg) * 32'(coef_rd);

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            sample_reg  <= '0;
            z_reg       <= '0;
            srdyo_reg   <= 1'b0;
            sum_en_reg  <= 1'b0;
            sum_rst_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            sample_reg  <= sample_next;
            z_reg       <= z_next;
            srdyo_reg   <= srdyo_next;
            sum_en_reg  <= sum_en_next;
            sum_rst_reg <= sum_rst_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        sample_next  = sample_reg;
        z_next       = z_reg;
        srdyo_next   = srdyo_reg;
        sum_en_next  = sum_en_reg;
        sum_rst_next = sum_rst_reg;
        busy_next    = busy_reg;
        case (state_reg)
            IDLE: begin
                if (srdyi_i) begin
                    sample_next  = x_i;
                    sum_rst_next = 1'b1;
                    busy_next    = 1'b1;
                    state_next   = CLR;
                end
            end
            CLR: begin
                sum_rst_next = 1'b0;
                k_next       = '0;
                state_next   = MUL;
            end
            MUL: begin
                if (k_reg == K_DONE) begin
                    srdyo_next  = 1'b0;
                    sum_en_next = 1'b0;
                    busy_next   = 1'b0;
                    k_next      = '0;
                    state_next  = IDLE;
                end else begin
                    z_next      = prod;
                    srdyo_next  = 1'b1;
                    sum_en_next = 1'b1;
                    k_next      = k_reg + (AW+1)'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef TAP_MULT_SEQ_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            drop_cnt_reg <= '0;
        end else if (srdyi_i && busy_reg && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_reg;
`endif

    assign z_o       = z_reg;
    assign srdyo_o   = srdyo_reg;
    assign sum_en_o  = sum_en_reg;
    assign sum_rst_o = sum_rst_reg;
    assign busy_o    = busy_reg;

endmodule

// File: tb/tb_tap_mult_seq.sv
// Directed testbench for tap_mult_seq with NTAPS=4 and XW=CW=16.
// Define TAP_MULT_SEQ_DROP_CNT_EN to also check drop_cnt_o.
module tb_tap_mult_seq;

    logic        clk = 1'b0;
    logic        GlobalReset = 1'b1;
    logic [15:0] x_i = '0;
    logic        srdyi_i = 1'b0;
    logic        coef_we_i = 1'b0;
    logic [1:0]  coef_addr_i = '0;
    logic [15:0] coef_data_i = '0;
    logic [31:0] z_o;
    logic        srdyo_o, sum_en_o, sum_rst_o, busy_o;
`ifdef TAP_MULT_SEQ_DROP_CNT_EN
    logic [7:0]  drop_cnt_o;
`endif

    int tests = 0;
    int fails = 0;

    tap_mult_seq #(.NTAPS(4), .XW(16), .CW(16)) dut (
        .clk(clk),
        .GlobalReset(GlobalReset),
        .x_i(x_i),
        .srdyi_i(srdyi_i),
        .coef_we_i(coef_we_i),
        .coef_addr_i(coef_addr_i),
        .coef_data_i(coef_data_i),
        .z_o(z_o),
        .srdyo_o(srdyo_o),
        .sum_en_o(sum_en_o),
        .sum_rst_o(sum_rst_o),
`ifdef TAP_MULT_SEQ_DROP_CNT_EN
        .drop_cnt_o(drop_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [1:0] addr, input int data);
        coef_we_i   = 1'b1;
        coef_addr_i = addr;
        coef_data_i = 16'(data);
        tick();
        coef_we_i   = 1'b0;
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
        write_coef(2'd0, c0);
        write_coef(2'd1, c1);
        write_coef(2'd2, c2);
        write_coef(2'd3, c3);
    endtask

    task automatic test_reset();
        GlobalReset = 1'b1;
        tick();
        tick();
        GlobalReset = 1'b0;
        tests++;
        if ({z_o, srdyo_o, sum_en_o, sum_rst_o, busy_o} !== 36'd0) begin
            fails++;
            $display("FAIL reset_outputs: got z=%h strobes=%b%b%b%b want all 0",
                     z_o, srdyo_o, sum_en_o, sum_rst_o, busy_o);
        end
        $display("[TB] reset: z=%h busy=%b", z_o, busy_o);
    endtask

    task automatic test_basic();
        int exp_z [4] = '{300, -200, 500, 100};
        load_coefs(3, -2, 5, 1);
        x_i = 16'd100; srdyi_i = 1'b1;
        tick();
        srdyi_i = 1'b0;
        tests++;
        if ({sum_rst_o, busy_o, srdyo_o} !== 3'b110) begin
            fails++;
            $display("FAIL basic_accept: got rst,busy,srdyo=%b%b%b want 110", sum_rst_o, busy_o, srdyo_o);
        end
        tick();
        tests++;
        if ({sum_rst_o, srdyo_o} !== 2'b00) begin
            fails++;
            $display("FAIL basic_clr: got rst,srdyo=%b%b want 00", sum_rst_o, srdyo_o);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (z_o !== 32'(exp_z[k]) || srdyo_o !== 1'b1 || sum_en_o !== 1'b1) begin
                fails++;
                $display("FAIL basic_prod%0d: got z=%0d srdyo=%b en=%b want z=%0d srdyo=1 en=1",
                         k, $signed(z_o), srdyo_o, sum_en_o, exp_z[k]);
            end
            $display("[TB] basic product %0d: z=%0d", k, $signed(z_o));
        end
        tick();
        tests++;
        if ({srdyo_o, sum_en_o, busy_o} !== 3'b000 || z_o !== 32'd100) begin
            fails++;
            $display("FAIL basic_end: got srdyo,en,busy=%b%b%b z=%0d want 000 z=100",
                     srdyo_o, sum_en_o, busy_o, $signed(z_o));
        end
    endtask

    task automatic test_extremes();
        load_coefs(-32768, 32767, 0, 0);
        x_i = 16'h8000; srdyi_i = 1'b1;
        tick();
        srdyi_i = 1'b0;
        tick();
        tick();
        tests++;
        if (z_o !== 32'h4000_0000) begin
            fails++;
            $display("FAIL ext_negneg: got %h want 40000000", z_o);
        end
        $display("[TB] extreme product 0: z=%h", z_o);
        tick();
        tests++;
        if (z_o !== 32'hC000_8000) begin
            fails++;
            $display("FAIL ext_posneg: got %h want c0008000", z_o);
        end
        $display("[TB] extreme product 1: z=%h", z_o);
        tick(); tick(); tick();
    endtask

    task automatic test_busy_drop();
        int exp_z [4] = '{300, -200, 500, 100};
        load_coefs(3, -2, 5, 1);
        x_i = 16'd100; srdyi_i = 1'b1;
        tick();
        srdyi_i = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            // Present a second sample so that it reaches the DUT at edge N+3.
            if (e == 3) begin
                x_i = 16'd50; srdyi_i = 1'b1;
            end
            tick();
            srdyi_i = 1'b0;
            if (e >= 2) begin
                tests++;
                if (z_o !== 32'(exp_z[e-2]) || srdyo_o !== 1'b1) begin
                    fails++;
                    $display("FAIL drop_prod%0d: got z=%0d srdyo=%b want z=%0d srdyo=1",
                             e-2, $signed(z_o), srdyo_o, exp_z[e-2]);
                end
            end
        end
        tick();
        tick();
        tests++;
        if ({busy_o, sum_rst_o, srdyo_o} !== 3'b000) begin
            fails++;
            $display("FAIL drop_no_burst: got busy,rst,srdyo=%b%b%b want 000", busy_o, sum_rst_o, srdyo_o);
        end
`ifdef TAP_MULT_SEQ_DROP_CNT_EN
        tests++;
        if (drop_cnt_o !== 8'd1) begin
            fails++;
            $display("FAIL drop_cnt: got %0d want 1", drop_cnt_o);
        end
`endif
        $display("[TB] busy drop: last z=%0d", $signed(z_o));
    endtask

    task automatic test_write_gating();
        int exp_z [4] = '{30, -20, 50, 10};
        x_i = 16'd10; srdyi_i = 1'b1;
        tick();
        srdyi_i = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            // Attempt a coefficient write while the DUT is in MUL. It must be ignored.
            if (k == 0) begin
                coef_we_i = 1'b1; coef_addr_i = 2'd0; coef_data_i = 16'd7;
            end
            tick();
            coef_we_i = 1'b0;
            tests++;
            if (z_o !== 32'(exp_z[k])) begin
                fails++;
                $display("FAIL gate_mul%0d: got %0d want %0d", k, $signed(z_o), exp_z[k]);
            end
        end
        tick();
        coef_we_i = 1'b1; coef_addr_i = 2'd0; coef_data_i = 16'd7;
        x_i = 16'd10; srdyi_i = 1'b1;
        tick();
        coef_we_i = 1'b0; srdyi_i = 1'b0;
        tick();
        tick();
        tests++;
        if (z_o !== 32'd70) begin
            fails++;
            $display("FAIL gate_idle_write: got %0d want 70", $signed(z_o));
        end
        $display("[TB] write gating: first product with new coef z=%0d", $signed(z_o));
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_midburst_reset();
        x_i = 16'd100; srdyi_i = 1'b1;
        tick();
        srdyi_i = 1'b0;
        tick();
        tick();
        GlobalReset = 1'b1;
        tick();
        GlobalReset = 1'b0;
        tests++;
        if ({z_o, srdyo_o, sum_en_o, sum_rst_o, busy_o} !== 36'd0) begin
            fails++;
            $display("FAIL midreset_outputs: got z=%h strobes=%b%b%b%b want all 0",
                     z_o, srdyo_o, sum_en_o, sum_rst_o, busy_o);
        end
        x_i = 16'd100; srdyi_i = 1'b1;
        tick();
        srdyi_i = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (z_o !== 32'd0 || srdyo_o !== 1'b1) begin
                fails++;
                $display("FAIL midreset_prod%0d: got z=%0d srdyo=%b want z=0 srdyo=1",
                         k, $signed(z_o), srdyo_o);
            end
        end
        tick();
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL midreset_end: got busy=%b want 0", busy_o);
        end
        $display("[TB] mid-burst reset: post-reset burst done, busy=%b", busy_o);
    endtask

    task automatic test_back_to_back();
        int ph;
        logic exp_rst, exp_out;
        int rst_pulses = 0;
        load_coefs(1, 2, 3, 4);
        x_i = 16'd5; srdyi_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            ph = i % 7;
            exp_rst = (ph == 0);
            exp_out = (ph >= 2 && ph <= 5);
            if (sum_rst_o) rst_pulses++;
            tests++;
            if (sum_rst_o !== exp_rst || srdyo_o !== exp_out) begin
                fails++;
                $display("FAIL b2b_cyc%0d: got rst=%b srdyo=%b want rst=%b srdyo=%b",
                         i, sum_rst_o, srdyo_o, exp_rst, exp_out);
            end
            if (exp_out) begin
                tests++;
                if (z_o !== 32'(5 * (ph - 1))) begin
                    fails++;
                    $display("FAIL b2b_z%0d: got %0d want %0d", i, $signed(z_o), 5 * (ph - 1));
                end
            end
        end
        srdyi_i = 1'b0;
        tests++;
        if (rst_pulses != 3) begin
            fails++;
            $display("FAIL b2b_pulses: got %0d want 3", rst_pulses);
        end
`ifdef TAP_MULT_SEQ_DROP_CNT_EN
        tests++;
        if (drop_cnt_o !== 8'd17) begin
            fails++;
            $display("FAIL b2b_drop_cnt: got %0d want 17", drop_cnt_o);
        end
`endif
        $display("[TB] back-to-back: %0d clear pulses in 20 cycles", rst_pulses);
        tick(); tick(); tick();
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: got busy=%b want 0", busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_busy_drop();
        test_write_gating();
        test_midburst_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
